store_write_buffer: RTL and testbench

//  Posted store buffer between the MEM stage and the data-memory bus. Accepts CPU

---
 rtl/store_write_buffer.sv | 84 ++++++++
 tb/tb_store_write_buffer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// store_write_buffer: posted store FIFO with byte-lane steering, tail merging and req/ack drain to memory
module store_write_buffer #(
   parameter int DEPTH = 4,
   parameter logic [2:0] ST_WORD = 3'd0,
   parameter logic [2:0] ST_HALF = 3'd1,
   parameter logic [2:0] ST_BYTE = 3'd2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        st_valid,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   input  logic [2:0]  st_type,
   output logic        st_ready,
   input  logic        ld_chk_valid,
   input  logic [31:0] ld_chk_addr,
   output logic        ld_hazard,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_byteen,
   input  logic        mem_ack,
   output logic        empty
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic {IDLE, REQ} state_t;
   state_t state, state_nx;
   logic [29:0] e_addr [DEPTH];
   logic [31:0] e_data [DEPTH];
   logic [3:0] e_be [DEPTH];
   logic [AW-1:0] head, tail, last;
   logic [AW:0] count;
   logic [3:0] be;
   logic [31:0] wdata;
   logic merge, wr, push, pop;
   logic unused_ok;
   assign unused_ok = &{1'b0, ld_chk_addr[1:0]};
   assign be = st_type == ST_WORD ? 4'hf :
               st_type == ST_HALF ? (st_addr[1] ? 4'hc : 4'h3) :
               st_type == ST_BYTE ? 4'b0001 << st_addr[1:0] : 4'h0;
   assign wdata = st_type == ST_WORD ? st_data :
                  st_type == ST_HALF ? (st_addr[1] ? {st_data[15:0], 16'h0} : {16'h0, st_data[15:0]}) :
                  {24'h0, st_data[7:0]} << {st_addr[1:0], 3'b000};
   assign last = tail - AW'(1);
   // the head entry cannot change while it is on the bus
   assign merge = count != '0 && e_addr[last] == st_addr[31:2] && !(last == head && state == REQ);
   assign st_ready = count < (AW+1)'(DEPTH) || merge;
   assign wr = st_valid && st_ready && be != 4'h0;
   assign push = wr && !merge;
   assign pop = state == REQ && mem_ack;
   assign mem_req = state == REQ;
   assign mem_addr = mem_req ? {e_addr[head], 2'b00} : 32'h0;
   assign mem_wdata = mem_req ? e_data[head] : 32'h0;
   assign mem_byteen = mem_req ? e_be[head] : 4'h0;
   assign empty = count == '0 && state == IDLE;
   always_comb begin
      ld_hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         ld_hazard = ld_hazard | (ld_chk_valid && {1'b0, AW'(i) - head} < count && e_addr[i] == ld_chk_addr[31:2]);
   end
   always_comb state_nx = state == IDLE ? (count != '0 ? REQ : IDLE) : (mem_ack ? IDLE : REQ);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         head <= '0;
         tail <= '0;
         count <= '0;
      end else begin
         state <= state_nx;
         if (push) tail <= tail + AW'(1);
         if (pop) head <= head + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   always_ff @(posedge clk)
      if (push) begin
         e_addr[tail] <= st_addr[31:2];
         e_data[tail] <= wdata;
         e_be[tail] <= be;
      end else if (wr) begin
         e_be[last] <= e_be[last] | be;
         for (int k = 0; k < 4; k++)
            if (be[k]) e_data[last][8*k +: 8] <= wdata[8*k +: 8];
      end
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: directed and random checks of the store buffer against a queue-based model
module tb_store_write_buffer;
   localparam int DEPTH = 4;
   localparam logic [2:0] W = 3'd0, H = 3'd1, B = 3'd2;
   logic clk = 0, reset = 1;
   logic st_valid = 0, st_ready, ld_chk_valid = 0, ld_hazard, mem_req, mem_ack = 0, empty;
   logic [31:0] st_addr = 0, st_data = 0, ld_chk_addr = 0, mem_addr, mem_wdata;
   logic [2:0] st_type = 0;
   logic [3:0] mem_byteen;
   int vectors = 0, miscompares = 0;
   typedef struct {logic [29:0] a; logic [31:0] d; logic [3:0] be;} ent_t;
   ent_t q[$];
   bit busy = 0;
   always #5 clk = ~clk;
   store_write_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
      .st_type(st_type), .st_ready(st_ready), .ld_chk_valid(ld_chk_valid), .ld_chk_addr(ld_chk_addr),
      .ld_hazard(ld_hazard), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_byteen(mem_byteen), .mem_ack(mem_ack), .empty(empty));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic void steer(input logic [31:0] addr, input logic [31:0] d, input logic [2:0] t,
                                 output logic [3:0] be, output logic [31:0] wd);
      int nb, lane;
      nb = t == W ? 4 : t == H ? 2 : t == B ? 1 : 0;
      lane = nb == 0 ? 0 : int'(addr[1:0]) / nb * nb;
      be = 4'(((1 << nb) - 1) << lane);
      wd = 32'((64'(d) & ((64'd1 << (8 * nb)) - 64'd1)) << (8 * lane));
   endfunction
   task automatic cyc(input bit v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] t,
                      input bit ack, input bit lv, input logic [31:0] la);
      logic [3:0] be;
      logic [31:0] wd;
      bit mok, rdy, hz;
      ent_t e;
      @(negedge clk);
      st_valid = v; st_addr = a; st_data = d; st_type = t; mem_ack = ack; ld_chk_valid = lv; ld_chk_addr = la;
      #1;
      steer(a, d, t, be, wd);
      mok = q.size() > 0 && q[q.size()-1].a == a[31:2] && !(busy && q.size() == 1);
      rdy = q.size() < DEPTH || mok;
      hz = 0;
      foreach (q[i]) if (q[i].a == la[31:2]) hz = lv;
      chk("st_ready", st_ready, rdy);
      chk("mem_req", mem_req, busy);
      chk("mem_addr", mem_addr, busy ? {q[0].a, 2'b00} : 32'h0);
      chk("mem_wdata", mem_wdata, busy ? q[0].d : 32'h0);
      chk("mem_byteen", mem_byteen, busy ? q[0].be : 4'h0);
      chk("ld_hazard", ld_hazard, hz);
      chk("empty", empty, q.size() == 0 && !busy);
      if (busy && ack) begin
         void'(q.pop_front());
         busy = 0;
      end else if (!busy && q.size() > 0) busy = 1;
      if (v && rdy && be != 4'h0) begin
         if (mok) begin
            e = q[q.size()-1];
            for (int k = 0; k < 4; k++) if (be[k]) e.d[8*k +: 8] = wd[8*k +: 8];
            e.be = e.be | be;
            q[q.size()-1] = e;
         end else q.push_back('{a[31:2], wd, be});
      end
   endtask
   task automatic idle(input bit ack);
      cyc(0, 0, 0, W, ack, 0, 0);
   endtask
   task automatic do_reset();
      @(negedge clk);
      st_valid = 0; mem_ack = 0; ld_chk_valid = 0;
      #2 reset = 1;
      #1;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_empty", empty, 1);
      chk("rst_st_ready", st_ready, 1);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_byteen", mem_byteen, 0);
      q.delete();
      busy = 0;
      @(negedge clk);
      reset = 0;
   endtask
   task automatic drain();
      for (int i = 0; i < 40 && (q.size() > 0 || busy); i++) idle(1);
      idle(0);
      chk("drained_empty", empty, 1);
   endtask
   initial begin
      do_reset();
      // byte store, ack on second request cycle
      cyc(1, 32'h13, 32'hAB, B, 0, 0, 0);
      idle(0);
      chk("t1_req_late", mem_req, 0);
      idle(0);
      chk("t1_req", mem_req, 1);
      chk("t1_addr", mem_addr, 32'h10);
      chk("t1_be", mem_byteen, 4'b1000);
      chk("t1_wdata", mem_wdata, 32'hAB000000);
      idle(1);
      idle(0);
      chk("t1_empty", empty, 1);
      // locked head, merge into second entry
      cyc(1, 32'h20, 32'h1234, H, 0, 0, 0);
      idle(0);
      cyc(1, 32'h21, 32'h56, B, 0, 0, 0);
      cyc(1, 32'h22, 32'h77, B, 0, 0, 0);
      idle(1);
      chk("t2_be1", mem_byteen, 4'b0011);
      chk("t2_wdata1", mem_wdata, 32'h00001234);
      idle(0);
      idle(1);
      chk("t2_be2", mem_byteen, 4'b0110);
      chk("t2_wdata2", mem_wdata, 32'h00775600);
      drain();
      // full queue: pop in ack cycle does not free a slot the same cycle
      for (int i = 0; i < 4; i++) cyc(1, 32'h80 + 32'(4 * i), 32'(i), W, 0, 0, 0);
      cyc(1, 32'h90, 32'h5, W, 1, 0, 0);
      chk("t3_full", st_ready, 0);
      cyc(1, 32'h90, 32'h5, W, 0, 0, 0);
      chk("t3_accept", st_ready, 1);
      drain();
      // load hazard
      cyc(1, 32'h40, 32'hCAFEF00D, W, 0, 0, 0);
      cyc(0, 0, 0, W, 0, 1, 32'h42);
      chk("t4_hit", ld_hazard, 1);
      cyc(0, 0, 0, W, 0, 1, 32'h44);
      chk("t4_miss", ld_hazard, 0);
      cyc(0, 0, 0, W, 1, 1, 32'h42);
      chk("t4_inflight", ld_hazard, 1);
      cyc(0, 0, 0, W, 0, 1, 32'h42);
      chk("t4_after_ack", ld_hazard, 0);
      // reset while request is outstanding
      cyc(1, 32'h50, 32'h11223344, W, 0, 0, 0);
      idle(0);
      idle(0);
      chk("t5_req", mem_req, 1);
      do_reset();
      idle(1);
      idle(1);
      chk("t5_no_req", mem_req, 0);
      chk("t5_empty", empty, 1);
      // invalid store type
      cyc(1, 32'h60, 32'hFFFF, 3'd7, 0, 0, 0);
      chk("t6_ready", st_ready, 1);
      idle(0);
      idle(0);
      chk("t6_no_req", mem_req, 0);
      chk("t6_empty", empty, 1);
      // random traffic over a small address window
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 99) == 0) do_reset();
         else cyc(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 15)), $urandom,
                  3'($urandom_range(0, 3)), $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                  32'h100 + 32'($urandom_range(0, 19)));
      end
      drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
